// File: rtl/lcd_byte_arbiter.sv
// lcd_byte_arbiter: round-robin share of one HD44780 4-bit byte engine between the
// command sequencer (req0) and the text writer (req1), with post-byte settle delay.
module lcd_byte_arbiter #(
   parameter int unsigned SHORT_WAIT_CYC = 2000,
   parameter int unsigned LONG_WAIT_CYC  = 80000,
   parameter int unsigned TIMEOUT_CYC    = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic       req0_is_data,
   input  logic [7:0] req0_byte,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic       req1_is_data,
   input  logic [7:0] req1_byte,
   output logic       req1_ready,
   output logic       eng_go,
   output logic       eng_is_data,
   output logic [7:0] eng_byte,
   input  logic       eng_done,
   output logic       busy,
   output logic       grant_id,
   output logic       err_timeout
);

   typedef enum logic [1:0] {ARB, WAIT_DONE, SETTLE} state_t;

   state_t      r_state, w_stateNext;
   logic [31:0] r_cnt, w_cntNext;
   logic        r_lastGrant, w_lastGrantNext;
   logic        r_engGo, w_engGoNext;
   logic        r_engIsData, w_engIsDataNext;
   logic [7:0]  r_engByte, w_engByteNext;
   logic        r_busy, w_busyNext;
   logic        r_grantId, w_grantIdNext;
   logic        r_errTimeout, w_errTimeoutNext;

   logic        w_win1;
   logic        w_xfer;
   logic        w_slowCmd;
   logic [31:0] w_settleCyc;
   logic        w_byteEnds;

   // req1 wins when it is the only one asking, or when req0 was served last
   assign w_win1     = req1_valid && (!req0_valid || !r_lastGrant);
   assign w_xfer     = (r_state == ARB) && !rst_n && (req0_valid || req1_valid);
   assign req0_ready = w_xfer && !w_win1;
   assign req1_ready = w_xfer && w_win1;

   // Clear display and return home need the long execution time
   assign w_slowCmd   = !r_engIsData &&
                        (r_engByte == 8'h01 || r_engByte == 8'h02 || r_engByte == 8'h03);
   assign w_settleCyc = w_slowCmd ? 32'(LONG_WAIT_CYC) : 32'(SHORT_WAIT_CYC);
   assign w_byteEnds  = eng_done || (r_cnt == 32'(TIMEOUT_CYC) - 32'd1);

   assign eng_go      = r_engGo;
   assign eng_is_data = r_engIsData;
   assign eng_byte    = r_engByte;
   assign busy        = r_busy;
   assign grant_id    = r_grantId;
   assign err_timeout = r_errTimeout;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) r_state <= ARB;
      else       r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext      = r_state;
      w_cntNext        = r_cnt;
      w_lastGrantNext  = r_lastGrant;
      w_engGoNext      = r_engGo;
      w_engIsDataNext  = r_engIsData;
      w_engByteNext    = r_engByte;
      w_busyNext       = r_busy;
      w_grantIdNext    = r_grantId;
      w_errTimeoutNext = r_errTimeout;
      case (r_state)
         ARB: begin
            if (w_xfer) begin
               w_engByteNext   = w_win1 ? req1_byte : req0_byte;
               w_engIsDataNext = w_win1 ? req1_is_data : req0_is_data;
               w_grantIdNext   = w_win1;
               w_lastGrantNext = w_win1;
               w_engGoNext     = 1'b1;
               w_busyNext      = 1'b1;
               w_cntNext       = 32'd0;
               w_stateNext     = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (w_byteEnds) begin
               w_engGoNext = 1'b0;
               if (!eng_done) w_errTimeoutNext = 1'b1;
               // Counter is loaded with N-1 so SETTLE lasts exactly N cycles
               if (w_settleCyc == 32'd0) begin
                  w_stateNext = ARB;
                  w_busyNext  = 1'b0;
                  w_cntNext   = 32'd0;
               end else begin
                  w_stateNext = SETTLE;
                  w_cntNext   = w_settleCyc - 32'd1;
               end
            end else begin
               w_cntNext = r_cnt + 32'd1;
            end
         end
         SETTLE: begin
            if (r_cnt == 32'd0) begin
               w_stateNext = ARB;
               w_busyNext  = 1'b0;
            end else begin
               w_cntNext = r_cnt - 32'd1;
            end
         end
         default: begin
            w_stateNext = ARB;
            w_busyNext  = 1'b0;
            w_engGoNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_cnt        <= 32'd0;
         r_lastGrant  <= 1'b1;
         r_engGo      <= 1'b0;
         r_engIsData  <= 1'b0;
         r_engByte    <= 8'h00;
         r_busy       <= 1'b0;
         r_grantId    <= 1'b0;
         r_errTimeout <= 1'b0;
      end else begin
         r_cnt        <= w_cntNext;
         r_lastGrant  <= w_lastGrantNext;
         r_engGo      <= w_engGoNext;
         r_engIsData  <= w_engIsDataNext;
         r_engByte    <= w_engByteNext;
         r_busy       <= w_busyNext;
         r_grantId    <= w_grantIdNext;
         r_errTimeout <= w_errTimeoutNext;
      end
   end

endmodule

// File: doc/lcd_byte_arbiter.md
Name: lcd_byte_arbiter

Overview:
- Shares the single HD44780 4-bit byte-send engine between two requesters:
  - requester 0: init/command sequencer.
  - requester 1: message/text writer.
- Arbitrates round-robin and hands the winning byte to the engine.
- Holds the engine request until the engine reports completion.
- Then enforces the HD44780 execution delay before granting again: 1.6 ms for clear/home, 40 us otherwise.

Parameters:
- SHORT_WAIT_CYC, 2000, post-byte settle cycles for normal commands and data (40 us at 50 MHz).
- LONG_WAIT_CYC, 80000, post-byte settle cycles for clear display / return home (1.6 ms at 50 MHz).
- TIMEOUT_CYC, 1000, max cycles waiting for eng_done before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-high (despite the name; codebase port naming)
- req0_valid  in  1  requester 0 has a byte
- req0_is_data  in  1  1=data (RS=1), 0=command
- req0_byte  in  8  byte value
- req0_ready  out  1  transfer accepted when req0_valid&&req0_ready
- req1_valid  in  1  requester 1 has a byte
- req1_is_data  in  1  as req0
- req1_byte  in  8  as req0
- req1_ready  out  1  as req0
- eng_go  out  1  level request to byte engine
- eng_is_data  out  1  RS for engine
- eng_byte  out  8  byte for engine
- eng_done  in  1  one-cycle completion pulse from engine
- busy  out  1  high in any state other than ARB
- grant_id  out  1  requester owning current/last transfer
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=1) to zero on all of these:
  - outputs: eng_go, eng_is_data, eng_byte, busy, grant_id, err_timeout.
  - internal: state=ARB, 32-bit counter, last_grant=1 (so req0 wins first).
  - ready outputs read 0 while reset is high.
- Reset asserted mid-transfer aborts immediately. No settle delay is owed afterwards.
- States: ARB, WAIT_DONE, SETTLE.
- ARB:
  - reqN_ready is combinational, only in ARB.
  - Only one valid: that requester wins.
  - Both valid: winner is the requester != last_grant.
  - Winner's ready=1, loser's ready=0. Neither valid: both ready=0.
  - On transfer, register these and go to WAIT_DONE next cycle:
    - eng_byte <= byte, eng_is_data <= is_data.
    - grant_id <= winner, last_grant <= winner, eng_go <= 1, counter <= 0.
- WAIT_DONE:
  - eng_go held 1; eng_byte and eng_is_data stable.
  - On eng_done: eng_go <= 0, load settle count, go to SETTLE.
  - Counter increments each cycle. At counter==TIMEOUT_CYC-1 without eng_done: eng_go <= 0, err_timeout <= 1 (sticky until reset), load settle count, go to SETTLE.
  - eng_done in any state other than WAIT_DONE is ignored.
- Settle count selection:
  - LONG_WAIT_CYC when eng_is_data==0 and eng_byte is 0x01, 0x02 or 0x03.
  - SHORT_WAIT_CYC otherwise.
- SETTLE:
  - Counts down one per cycle. Returns to ARB in the cycle after the count reaches 0, so SETTLE occupies exactly N cycles.
  - N==0 bypasses SETTLE: WAIT_DONE goes directly to ARB.
- busy is registered: 1 from the cycle after transfer until the cycle ARB is re-entered.
- Minimum acceptance-to-acceptance spacing = engine latency + settle + 1 cycle.
- Requester inputs are sampled only at transfer. Changes during busy have no effect.

Test Plan:
- Reset, then req0_valid=1, cmd 0x28:
  - req0_ready=1 same cycle; next cycle eng_go=1, eng_byte=0x28, eng_is_data=0, busy=1, grant_id=0.
  - eng_done 10 cycles later: eng_go falls next cycle; ARB re-entered exactly 2000 cycles later.
- Both valid after reset, req0=0x41 data, req1=0x42 data:
  - grants in order req0, req1, req0, req1 while both remain valid.
  - each grant separated by engine latency + 2000 + 1 cycles.
- req0 cmd 0x01 (clear): settle is 80000 cycles.
  - Also with is_data=1, 0x01: settle is 2000 cycles.
- Engine never asserts eng_done:
  - eng_go drops after 1000 cycles and err_timeout=1.
  - Settle still applied; next request granted.
  - err_timeout stays 1 until reset.
- rst_n pulsed high during SETTLE and during WAIT_DONE:
  - all outputs 0 asynchronously.
  - after release, a pending req0 is accepted on the first clock.
- Spurious eng_done in ARB and SETTLE: no state change, no counter effect.
